// File: rtl/counter_checker_if.sv
// Signal bundle between the counter-under-test harness and its response checker.
// No handshake: every signal is sampled on each rising clk edge, and the harness
// must present the counter's registered outputs alongside the same commands.
interface counter_checker_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             check_en;
  logic             enable;
  logic [1:0]       mode;
  logic [3:0]       D;
  logic             load;
  logic             rco;
  logic [N-1:0]     Q;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_err_exp;
  logic [N-1:0]     first_err_got;
  logic             halted;

  modport master (
    output check_en, enable, mode, D, load, rco, Q,
    input  mismatch, err_count, first_err_exp, first_err_got, halted
  );

  modport slave (
    input  check_en, enable, mode, D, load, rco, Q,
    output mismatch, err_count, first_err_exp, first_err_got, halted
  );
endinterface

// File: rtl/counter_checker.sv
// Lock-step response checker for the cascaded counter: keeps its own model of the
// counter, compares the counter's registered outputs one edge later, logs failures.
module counter_checker #(
  parameter int N           = 32,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  counter_checker_if.slave   bus,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [N-1:0]     ALL_ONES   = '1;
  localparam logic [N-1:0]     ADD3_LIMIT = ALL_ONES - N'(2);
  localparam logic [CNT_W-1:0] ERR_MAX    = '1;

  state_t           state, state_nxt;
  logic [N-1:0]     exp_q, q_nxt;
  logic             exp_load, load_nxt;
  logic             exp_rco, rco_nxt;
  logic             diff, fail;
  logic             captured;
  logic             mismatch_r;
  logic [CNT_W-1:0] err_cnt;
  logic [N-1:0]     cap_exp, cap_got;

  // Model of the counter, advanced with the same commands the counter samples.
  always_comb begin
    q_nxt    = exp_q;
    load_nxt = 1'b0;
    rco_nxt  = 1'b0;
    if (bus.enable) begin
      case (bus.mode)
        2'b00: begin
          q_nxt   = exp_q + N'(1);
          rco_nxt = (exp_q == ALL_ONES);
        end
        2'b01: begin
          q_nxt   = exp_q - N'(1);
          rco_nxt = (exp_q == '0);
        end
        2'b10: begin
          q_nxt   = exp_q + N'(3);
          rco_nxt = (exp_q >= ADD3_LIMIT);
        end
        default: begin
          q_nxt    = {(N/4){bus.D}};
          load_nxt = 1'b1;
        end
      endcase
    end
  end

  // Counter outputs and model both moved on the previous edge; compare them now.
  assign diff = (bus.Q != exp_q) || (bus.load != exp_load) || (bus.rco != exp_rco);
  assign fail = (state == CHECK) && diff;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.check_en) state_nxt = CHECK;
      CHECK: begin
        if (fail && STOP_ON_ERR) state_nxt = HALT;
        else if (!bus.check_en)  state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      exp_q      <= '0;
      exp_load   <= 1'b0;
      exp_rco    <= 1'b0;
      mismatch_r <= 1'b0;
      err_cnt    <= '0;
      captured   <= 1'b0;
      cap_exp    <= '0;
      cap_got    <= '0;
    end else begin
      state      <= state_nxt;
      exp_q      <= q_nxt;
      exp_load   <= load_nxt;
      exp_rco    <= rco_nxt;
      mismatch_r <= fail;
      if (fail && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + CNT_W'(1);
      if (fail && !captured) begin
        captured <= 1'b1;
        cap_exp  <= exp_q;
        cap_got  <= bus.Q;
      end
    end
  end

  assign bus.mismatch      = mismatch_r;
  assign bus.err_count     = err_cnt;
  assign bus.first_err_exp = cap_exp;
  assign bus.first_err_got = cap_got;
  assign bus.halted        = (state == HALT);
  assign fsm_state         = state;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: three checker configurations share one stimulus stream;
// a scoreboard predicts each checker's outputs from an ideal counter plus injected faults.
module tb_counter_checker;

  localparam int S_IDLE  = 0;
  localparam int S_CHECK = 1;
  localparam int S_HALT  = 2;

  typedef struct packed {
    logic        mismatch;
    logic [15:0] err;
    logic [31:0] fexp;
    logic [31:0] fgot;
    logic        halted;
  } exp_t;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        check_en, enable, load_drv, rco_drv;
  logic [1:0]  mode;
  logic [3:0]  d;
  logic [31:0] q_drv;
  logic [1:0]  st_a, st_h, st_s;

  counter_checker_if #(.N(32), .CNT_W(16)) bus_a ();
  counter_checker_if #(.N(32), .CNT_W(16)) bus_h ();
  counter_checker_if #(.N(32), .CNT_W(4))  bus_s ();

  assign bus_a.check_en = check_en;
  assign bus_a.enable   = enable;
  assign bus_a.mode     = mode;
  assign bus_a.D        = d;
  assign bus_a.load     = load_drv;
  assign bus_a.rco      = rco_drv;
  assign bus_a.Q        = q_drv;
  assign bus_h.check_en = check_en;
  assign bus_h.enable   = enable;
  assign bus_h.mode     = mode;
  assign bus_h.D        = d;
  assign bus_h.load     = load_drv;
  assign bus_h.rco      = rco_drv;
  assign bus_h.Q        = q_drv;
  assign bus_s.check_en = check_en;
  assign bus_s.enable   = enable;
  assign bus_s.mode     = mode;
  assign bus_s.D        = d;
  assign bus_s.load     = load_drv;
  assign bus_s.rco      = rco_drv;
  assign bus_s.Q        = q_drv;

  counter_checker #(.N(32), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .fsm_state(st_a));
  counter_checker #(.N(32), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .reset(reset), .bus(bus_h), .fsm_state(st_h));
  counter_checker #(.N(32), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s), .fsm_state(st_s));

  // scoreboard state
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q_a[$];
  exp_t q_h[$];
  exp_t q_s[$];

  // ideal counter and per-configuration checker expectations
  logic [31:0] cnt_q;
  logic        cnt_load, cnt_rco;
  int          m_st[3];
  int          m_err[3];
  bit          m_cap[3];
  logic [31:0] m_fexp[3];
  logic [31:0] m_fgot[3];
  int          err_max[3] = '{65535, 65535, 15};
  bit          stop_on[3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic mm,
                           input logic [15:0] ec, input logic [31:0] fe,
                           input logic [31:0] fg, input logic h);
    chk({tag, ".mismatch"},      32'(mm), 32'(e.mismatch));
    chk({tag, ".err_count"},     32'(ec), 32'(e.err));
    chk({tag, ".first_err_exp"}, fe,      e.fexp);
    chk({tag, ".first_err_got"}, fg,      e.fgot);
    chk({tag, ".halted"},        32'(h),  32'(e.halted));
  endtask

  task automatic model_reset();
    cnt_q    = '0;
    cnt_load = 1'b0;
    cnt_rco  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_st[k]   = S_IDLE;
      m_err[k]  = 0;
      m_cap[k]  = 1'b0;
      m_fexp[k] = '0;
      m_fgot[k] = '0;
    end
  endtask

  // Ideal counter computed with plain modular arithmetic.
  task automatic counter_step(input logic en, input logic [1:0] md, input logic [3:0] dd);
    longint v;
    longint m;
    v = longint'(cnt_q);
    m = 64'h1_0000_0000;
    cnt_load = 1'b0;
    cnt_rco  = 1'b0;
    if (en) begin
      case (md)
        2'd0: begin cnt_rco = (v == m - 1); cnt_q = 32'((v + 1) % m);     end
        2'd1: begin cnt_rco = (v == 0);     cnt_q = 32'((v - 1 + m) % m); end
        2'd2: begin cnt_rco = (v >= m - 3); cnt_q = 32'((v + 3) % m);     end
        default: begin cnt_q = {8{dd}}; cnt_load = 1'b1; end
      endcase
    end
  endtask

  // driver: one clock of stimulus; iq/il/ir corrupt the counter outputs seen by the checkers
  task automatic cycle(input logic ce, input logic en, input logic [1:0] md,
                       input logic [3:0] dd, input logic [31:0] iq,
                       input logic il, input logic ir);
    exp_t e;
    logic bad, hit;
    @(negedge clk);
    check_en = ce;
    enable   = en;
    mode     = md;
    d        = dd;
    q_drv    = cnt_q ^ iq;
    load_drv = cnt_load ^ il;
    rco_drv  = cnt_rco ^ ir;
    bad      = (iq != 0) || il || ir;
    for (int k = 0; k < 3; k++) begin
      hit = (m_st[k] == S_CHECK) && bad;
      if (hit) begin
        if (m_err[k] < err_max[k]) m_err[k]++;
        if (!m_cap[k]) begin
          m_cap[k]  = 1'b1;
          m_fexp[k] = cnt_q;
          m_fgot[k] = cnt_q ^ iq;
        end
      end
      if (m_st[k] == S_IDLE) begin
        if (ce) m_st[k] = S_CHECK;
      end else if (m_st[k] == S_CHECK) begin
        if (hit && stop_on[k]) m_st[k] = S_HALT;
        else if (!ce)          m_st[k] = S_IDLE;
      end
      e.mismatch = hit;
      e.err      = 16'(m_err[k]);
      e.fexp     = m_fexp[k];
      e.fgot     = m_fgot[k];
      e.halted   = (m_st[k] == S_HALT);
      case (k)
        0:       q_a.push_back(e);
        1:       q_h.push_back(e);
        default: q_s.push_back(e);
      endcase
    end
    counter_step(en, md, dd);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a.mm"},   32'(bus_a.mismatch),  0);
    chk({tag, ".a.err"},  32'(bus_a.err_count), 0);
    chk({tag, ".a.fexp"}, bus_a.first_err_exp,  0);
    chk({tag, ".a.fgot"}, bus_a.first_err_got,  0);
    chk({tag, ".h.halt"}, 32'(bus_h.halted),    0);
    chk({tag, ".h.err"},  32'(bus_h.err_count), 0);
    chk({tag, ".s.err"},  32'(bus_s.err_count), 0);
    chk({tag, ".s.mm"},   32'(bus_s.mismatch),  0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    check_en = 1'b0;
    enable   = 1'b0;
    mode     = 2'd0;
    d        = 4'd0;
    q_drv    = '0;
    load_drv = 1'b0;
    rco_drv  = 1'b0;
    reset    = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: pops one expectation per checker after each edge that was stimulated
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check_dut("a", e, bus_a.mismatch, bus_a.err_count,
                  bus_a.first_err_exp, bus_a.first_err_got, bus_a.halted);
      end
      if (q_h.size() != 0) begin
        e = q_h.pop_front();
        check_dut("h", e, bus_h.mismatch, bus_h.err_count,
                  bus_h.first_err_exp, bus_h.first_err_got, bus_h.halted);
      end
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        check_dut("s", e, bus_s.mismatch, {12'd0, bus_s.err_count},
                  bus_s.first_err_exp, bus_s.first_err_got, bus_s.halted);
      end
    end
  end

  initial begin
    logic [31:0] iq;
    logic        il, ir;
    int          kind;
    check_en = 1'b0;
    enable   = 1'b0;
    mode     = 2'd0;
    d        = 4'd0;
    q_drv    = '0;
    load_drv = 1'b0;
    rco_drv  = 1'b0;
    model_reset();
    apply_reset("reset0");

    // count up 1..10
    repeat (10) cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);
    // load A, decrement; load 0, decrement through zero
    cycle(1, 1, 2'd3, 4'hA, 0, 0, 0);
    repeat (2) cycle(1, 1, 2'd1, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd3, 4'h0, 0, 0, 0);
    repeat (2) cycle(1, 1, 2'd1, 4'h0, 0, 0, 0);
    // load F, add 3 across the wrap; then the 2^N-3 / 2^N-4 boundaries
    cycle(1, 1, 2'd3, 4'hF, 0, 0, 0);
    repeat (2) cycle(1, 1, 2'd2, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd3, 4'hF, 0, 0, 0);
    repeat (2) cycle(1, 1, 2'd1, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd2, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd3, 4'hF, 0, 0, 0);
    repeat (3) cycle(1, 1, 2'd1, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd2, 4'h0, 0, 0, 0);
    repeat (2) cycle(1, 0, 2'd0, 4'h0, 0, 0, 0);
    chk("clean_run.err_a", 32'(bus_a.err_count), 0);

    // single bit-5 fault
    cycle(1, 1, 2'd0, 4'h0, 32'h20, 0, 0);
    cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);
    chk("bit5.err_a", 32'(bus_a.err_count), 1);
    chk("bit5.xor",   bus_a.first_err_exp ^ bus_a.first_err_got, 32'h20);
    chk("bit5.halt_h", 32'(bus_h.halted), 1);

    // fault on the same edge check_en falls, then a fault while idle
    cycle(0, 1, 2'd0, 4'h0, 0, 1, 0);
    cycle(0, 1, 2'd0, 4'h0, 0, 0, 1);
    cycle(1, 1, 2'd0, 4'h0, 0, 0, 1);
    cycle(1, 1, 2'd0, 4'h0, 0, 1, 0);
    cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);

    // three consecutive faults against the halting checker
    apply_reset("reset1");
    repeat (2) cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);
    cycle(1, 1, 2'd0, 4'h0, 32'h1, 0, 0);
    cycle(1, 1, 2'd2, 4'h0, 32'h8000_0000, 0, 0);
    cycle(1, 1, 2'd1, 4'h0, 0, 1, 0);
    repeat (3) cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);
    chk("halt.err_h", 32'(bus_h.err_count), 1);
    chk("halt.halted_h", 32'(bus_h.halted), 1);
    chk("halt.err_a", 32'(bus_a.err_count), 3);

    // continuous faults saturate the 4-bit counter, then reset mid-run
    repeat (20) cycle(1, 1, 2'(($urandom_range(0, 2))), 4'h0, $urandom | 32'h1, 0, 0);
    cycle(1, 1, 2'd0, 4'h0, 0, 0, 0);
    chk("sat.err_s", 32'(bus_s.err_count), 15);
    chk("sat.err_a", 32'(bus_a.err_count), 23);
    apply_reset("reset_mid");

    // randomized traffic
    for (int i = 0; i < 450; i++) begin
      if (i % 150 == 149) apply_reset("reset_rand");
      iq   = '0;
      il   = 1'b0;
      ir   = 1'b0;
      kind = $urandom_range(0, 11);
      case (kind)
        0: iq = 32'h1 << $urandom_range(0, 31);
        1: il = 1'b1;
        2: ir = 1'b1;
        3: iq = $urandom;
        default: ;
      endcase
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), iq, il, ir);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", 32'(q_a.size() + q_h.size() + q_s.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Response checker for the 32-bit cascaded counter.
- Runs in lock-step with the counter under test. Receives the same command inputs (enable, mode, D) and the counter's registered outputs (load, rco, Q).
- Keeps its own cycle-accurate model of the counter and compares the counter's outputs against it every cycle.
- Reports per-cycle mismatches, a saturating error count and a snapshot of the first failure. It sits in the testbench/FPGA harness next to the counter.

Parameters:
N, 32, counter width in bits; must be a multiple of 4.
CNT_W, 16, width of the error counter.
STOP_ON_ERR, 0, 1 = stop checking after the first mismatch (sticky HALT); 0 = keep checking.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
check_en  input  1  1 = compare outputs; 0 = track the model only.
enable  input  1  counter enable, same signal the counter sees.
mode  input  2  counter mode, same signal the counter sees.
D  input  4  counter load nibble, same signal the counter sees.
load  input  1  counter load output.
rco  input  1  counter ripple-carry output.
Q  input  N  counter value output.
mismatch  output  1  one-cycle pulse for each cycle that failed comparison.
err_count  output  CNT_W  number of failed cycles, saturating.
first_err_exp  output  N  expected Q captured at the first mismatch.
first_err_got  output  N  observed Q captured at the first mismatch.
halted  output  1  1 while in HALT.

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0. Internal state on reset:
  - exp_q = 0, exp_load = 0, exp_rco = 0
  - state = IDLE
  - first-error capture flag cleared.
- Model update. The model updates on every rising edge using the same enable/mode/D the counter samples:
  - enable=0: exp_q holds; exp_load = 0; exp_rco = 0.
  - mode 00: exp_q + 1 (mod 2^N). exp_rco = 1 iff old exp_q = all ones.
  - mode 01: exp_q − 1 (mod 2^N). exp_rco = 1 iff old exp_q = 0.
  - mode 10: exp_q + 3 (mod 2^N). exp_rco = 1 iff old exp_q ≥ 2^N − 3.
  - mode 11: exp_q = D replicated into every nibble. exp_load = 1; exp_rco = 0.
  - exp_load = 0 for modes 00/01/10.
- Compare timing:
  - The counter's outputs and the model both change on edge t.
  - The comparison is made on edge t+1 (registered compare).
  - mismatch is high for the cycle following edge t+1 when Q≠exp_q, load≠exp_load, or rco≠exp_rco, provided the state at edge t+1 is CHECK.
  - Latency: output divergence to mismatch assertion = 1 clock.
- State machine:
  - IDLE: no compares. Go to CHECK when check_en=1. The first compare happens on the next edge.
  - CHECK: compare every cycle. Go to IDLE when check_en=0. Go to HALT on a mismatch when STOP_ON_ERR=1.
  - HALT: no compares; mismatch = 0; halted = 1. Leaves HALT only on reset. The model keeps tracking the inputs.
- The model is updated in every state, including IDLE and HALT, so re-entering CHECK needs no resynchronisation.
- err_count increments by 1 per mismatching cycle and saturates at 2^CNT_W − 1. A cycle with several bad fields counts once.
- first_err_exp / first_err_got are loaded on the first mismatch after reset and then frozen until the next reset.
- Reset asserted mid-run: everything clears immediately, without waiting for a clock edge. The counter is reset by the same signal, so both sides restart at Q = 0.
- Simultaneous mismatch and check_en falling on the same edge: the mismatch is still reported, and the state goes to IDLE (or to HALT if STOP_ON_ERR=1; HALT has priority).

Test Plan:
1. Reset, check_en=1, enable=1, mode=00 for 10 cycles with a correct counter → Q runs 1..10; mismatch never asserts; err_count=0.
2. mode=11, D=4'hA, then mode=01 from Q=0xAAAAAAAA; then load D=0 and decrement → load=1 for exactly one cycle; Q=0xAAAAAAA9 next; the decrement from 0 gives Q=0xFFFFFFFF with rco=1; no mismatch.
3. Load D=4'hF, then mode=10 → Q wraps 0xFFFFFFFF → 0x00000002 with rco=1; no mismatch.
4. Force Q bit 5 wrong for one cycle → mismatch pulses once, one clock later; err_count=1; first_err_got differs from first_err_exp only in bit 5.
5. STOP_ON_ERR=1, inject 3 consecutive bad cycles → err_count=1; halted=1; mismatch stays low afterwards.
6. Inject errors continuously with CNT_W=4 → err_count saturates at 15. Assert reset mid-run → all outputs are 0 immediately.
